// File: rtl/arcade_input_mapper.sv
// Maps PS/2 keyboard events and per-player joystick words onto registered arcade
// button vectors, with per-player rotation and autofire, and fixed-width coin pulses per slot.
module arcade_input_mapper #(
    parameter int          NPLAYERS    = 2,
    parameter logic [15:0] COIN_CYCLES = 16'd50000,
    parameter logic [23:0] AF_PERIOD   = 24'd600000,
    parameter bit          START_COINS = 1'b1
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [16*NPLAYERS-1:0] joy_in,
    input  logic                   merge_joy,
    input  logic [1:0]             rotate,
    input  logic [NPLAYERS-1:0]    autofire_en,
    output logic [6*NPLAYERS-1:0]  player_btn,
    output logic [NPLAYERS-1:0]    coin_out
);

    localparam int K1_UP = 0, K1_DOWN = 1, K1_LEFT = 2, K1_RIGHT = 3;
    localparam int K1_FIRE_A = 4, K1_FIRE_B = 5, K1_START_A = 6, K1_START_B = 7, K1_COIN = 8;
    localparam int K2_UP = 9, K2_DOWN = 10, K2_LEFT = 11, K2_RIGHT = 12;
    localparam int K2_FIRE = 13, K2_START_A = 14, K2_START_B = 15, K2_COIN = 16;
    localparam int NK = 17;

    logic [NK-1:0] key_q, key_d;
    logic          toggle_q, toggle_d;
    logic          prime_q, prime_d;
    logic          kb_event;
    logic [6:0]    joy_or;
    logic          unused_joy_hi;

    assign unused_joy_hi = ^joy_in;

    // prime_q stays low for the first cycle after reset so stale toggles and held requests never fire
    always_comb begin
        toggle_d = ps2_key[10];
        prime_d  = 1'b1;
        kb_event = prime_q && (ps2_key[10] != toggle_q);
        key_d    = key_q;
        if (kb_event) begin
            case ({ps2_key[8], ps2_key[7:0]})
                9'h175:  key_d[K1_UP]      = ps2_key[9];
                9'h172:  key_d[K1_DOWN]    = ps2_key[9];
                9'h16B:  key_d[K1_LEFT]    = ps2_key[9];
                9'h174:  key_d[K1_RIGHT]   = ps2_key[9];
                9'h029:  key_d[K1_FIRE_A]  = ps2_key[9];
                9'h014:  key_d[K1_FIRE_B]  = ps2_key[9];
                9'h005:  key_d[K1_START_A] = ps2_key[9];
                9'h016:  key_d[K1_START_B] = ps2_key[9];
                9'h02E:  key_d[K1_COIN]    = ps2_key[9];
                9'h02D:  key_d[K2_UP]      = ps2_key[9];
                9'h02B:  key_d[K2_DOWN]    = ps2_key[9];
                9'h023:  key_d[K2_LEFT]    = ps2_key[9];
                9'h034:  key_d[K2_RIGHT]   = ps2_key[9];
                9'h01C:  key_d[K2_FIRE]    = ps2_key[9];
                9'h006:  key_d[K2_START_A] = ps2_key[9];
                9'h01E:  key_d[K2_START_B] = ps2_key[9];
                9'h036:  key_d[K2_COIN]    = ps2_key[9];
                default: ;
            endcase
        end
        if (NPLAYERS < 2) key_d[K2_UP +: 8] = '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_q    <= '0;
            toggle_q <= 1'b0;
            prime_q  <= 1'b0;
        end else begin
            key_q    <= key_d;
            toggle_q <= toggle_d;
            prime_q  <= prime_d;
        end
    end

    always_comb begin
        joy_or = '0;
        for (int p = 0; p < NPLAYERS; p++) joy_or = joy_or | joy_in[16*p +: 7];
    end

    for (genvar gi = 0; gi < NPLAYERS; gi++) begin : g_player
        logic [6:0]  kb_w, joy_w, raw;
        logic        up_r, dn_r, lf_r, rt_r;
        logic        fire_o, start_edge, coin_req, coin_edge;
        logic [23:0] af_cnt_q, af_cnt_d;
        logic        af_phase_q, af_phase_d;
        logic        start_prev_q, start_prev_d;
        logic        req_prev_q, req_prev_d;
        logic [15:0] coin_cnt_q, coin_cnt_d;
        logic [5:0]  btn_q, btn_d;
        logic        coin_q, coin_d;

        // Keyboard contribution in joystick bit order: {coin, start, fire, up, down, left, right}
        if (gi == 0) begin : g_kb1
            assign kb_w = {key_q[K1_COIN], key_q[K1_START_A] | key_q[K1_START_B],
                           key_q[K1_FIRE_A] | key_q[K1_FIRE_B], key_q[K1_UP],
                           key_q[K1_DOWN], key_q[K1_LEFT], key_q[K1_RIGHT]};
        end else if (gi == 1) begin : g_kb2
            assign kb_w = {key_q[K2_COIN], key_q[K2_START_A] | key_q[K2_START_B],
                           key_q[K2_FIRE], key_q[K2_UP], key_q[K2_DOWN],
                           key_q[K2_LEFT], key_q[K2_RIGHT]};
        end else begin : g_kb_none
            assign kb_w = '0;
        end

        assign joy_w = merge_joy ? ((gi == 0) ? joy_or : 7'd0) : joy_in[16*gi +: 7];
        assign raw   = joy_w | kb_w;

        always_comb begin
            up_r = raw[3];
            dn_r = raw[2];
            lf_r = raw[1];
            rt_r = raw[0];
            case (rotate)
                2'd1: begin up_r = raw[1]; dn_r = raw[0]; lf_r = raw[2]; rt_r = raw[3]; end
                2'd2: begin up_r = raw[2]; dn_r = raw[3]; lf_r = raw[0]; rt_r = raw[1]; end
                2'd3: begin up_r = raw[0]; dn_r = raw[1]; lf_r = raw[3]; rt_r = raw[2]; end
                default: ;
            endcase

            // af_cnt_q == 0 means "not yet pressed"; the press cycle itself fires
            af_cnt_d   = '0;
            af_phase_d = 1'b0;
            fire_o     = raw[4];
            if (autofire_en[gi] && raw[4]) begin
                if (af_cnt_q == '0) begin
                    af_cnt_d   = 24'd1;
                    af_phase_d = 1'b1;
                end else if (af_cnt_q >= AF_PERIOD) begin
                    af_cnt_d   = 24'd1;
                    af_phase_d = ~af_phase_q;
                end else begin
                    af_cnt_d   = af_cnt_q + 24'd1;
                    af_phase_d = af_phase_q;
                end
                fire_o = af_phase_d;
            end

            start_prev_d = raw[5];
            start_edge   = prime_q & raw[5] & ~start_prev_q;
            coin_req     = raw[6] | (START_COINS & start_edge);
            req_prev_d   = coin_req;
            coin_edge    = prime_q & coin_req & ~req_prev_q;

            // A running pulse swallows any new edge; it is neither extended nor queued
            coin_cnt_d = coin_cnt_q;
            if (coin_cnt_q != '0) coin_cnt_d = coin_cnt_q - 16'd1;
            else if (coin_edge)   coin_cnt_d = COIN_CYCLES;
            coin_d = (coin_cnt_d != '0);

            btn_d = {raw[5], fire_o, rt_r, lf_r, dn_r, up_r};
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                af_cnt_q     <= '0;
                af_phase_q   <= 1'b0;
                start_prev_q <= 1'b0;
                req_prev_q   <= 1'b0;
                coin_cnt_q   <= '0;
                btn_q        <= '0;
                coin_q       <= 1'b0;
            end else begin
                af_cnt_q     <= af_cnt_d;
                af_phase_q   <= af_phase_d;
                start_prev_q <= start_prev_d;
                req_prev_q   <= req_prev_d;
                coin_cnt_q   <= coin_cnt_d;
                btn_q        <= btn_d;
                coin_q       <= coin_d;
            end
        end

        assign player_btn[6*gi +: 6] = btn_q;
        assign coin_out[gi]          = coin_q;
    end

endmodule
